// File: rtl/xorshift_pkg.sv
// Shared constants, tag type and the reference XOR/conditional-shift function
// for the round-robin xorshift arbiter.
package xorshift_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 2;
  localparam int DEF_TAG_W = 2;
  localparam int DEF_CNT_W = 16;

  typedef logic [DEF_TAG_W-1:0] tag_t;

  // The MSB of a selects whether (a^b) is shifted left by one; the bit shifted out is lost.
  function automatic logic [DEF_WIDTH-1:0] xorshift_f(input logic [DEF_WIDTH-1:0] a,
                                                      input logic [DEF_WIDTH-1:0] b);
    logic [DEF_WIDTH-1:0] x;
    x = a ^ b;
    return a[DEF_WIDTH-1] ? {x[DEF_WIDTH-2:0], 1'b0} : x;
  endfunction

endpackage

// File: rtl/xorshift_unit.sv
// Combinational datapath: y = a[MSB] ? ((a^b) << 1) : (a^b), truncated to WIDTH.
module xorshift_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] w_x;

  assign w_x = a ^ b;
  assign y   = a[WIDTH-1] ? {w_x[WIDTH-2:0], 1'b0} : w_x;

endmodule

// File: rtl/xorshift_rr_arbiter.sv
// Round-robin arbiter sharing one xorshift datapath among NREQ requesters,
// with a one-deep registered output stage that supports backpressure.
module xorshift_rr_arbiter
  import xorshift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int TAG_W = DEF_TAG_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic [CNT_W-1:0]      op_count
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [TAG_W-1:0] r_out_tag;
  logic [TAG_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0] r_op_count;

  logic             w_can_accept;
  logic             w_found;
  logic             w_grant;
  logic [TAG_W-1:0] w_grant_idx;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_y;

  // Scan offsets from highest to lowest so the closest valid requester to ptr wins.
  function automatic logic [TAG_W:0] rr_search(input logic [NREQ-1:0]  valid,
                                               input logic [TAG_W-1:0] ptr);
    logic [TAG_W:0] res;
    int             idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (valid[idx]) res = {1'b1, TAG_W'(idx)};
    end
    return res;
  endfunction

  assign {w_found, w_grant_idx} = rr_search(req_valid, r_rr_ptr);
  assign w_can_accept = !r_out_valid || out_ready;
  assign w_grant      = en && w_can_accept && w_found;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = w_grant && (w_grant_idx == TAG_W'(gi));
  end

  assign w_a = req_a[int'(w_grant_idx)*WIDTH +: WIDTH];
  assign w_b = req_b[int'(w_grant_idx)*WIDTH +: WIDTH];

  xorshift_unit #(.WIDTH(WIDTH)) u_unit (
    .a (w_a),
    .b (w_b),
    .y (w_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_rr_ptr    <= '0;
      r_op_count  <= '0;
    end else if (w_grant) begin
      // A new result may replace one draining this same cycle without a bubble.
      r_out_valid <= 1'b1;
      r_out_data  <= w_y;
      r_out_tag   <= w_grant_idx;
      r_rr_ptr    <= TAG_W'((int'(w_grant_idx) + 1) % NREQ);
      r_op_count  <= r_op_count + CNT_W'(1);
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_xorshift_rr_arbiter.sv
// Randomized and directed bench for xorshift_rr_arbiter against a behavioural model.
module tb_xorshift_rr_arbiter;
  import xorshift_pkg::*;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int TW = 2;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [TW-1:0]   out_tag;
  logic [CW-1:0]   op_count;

  xorshift_rr_arbiter #(.WIDTH(W), .NREQ(N), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: output register contents, last granted requester, accepted-op count.
  bit       m_valid;
  logic [W-1:0] m_data;
  tag_t     m_tag;
  int       m_last;
  int       m_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_tag   = '0;
    m_last  = N - 1;
    m_count = 0;
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({ctx, ".out_data"},  32'(out_data),  32'(m_data));
    check({ctx, ".out_tag"},   32'(out_tag),   32'(m_tag));
    check({ctx, ".op_count"},  32'(op_count),  32'(m_count % 65536));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic [N-1:0] v, input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic [W-1:0] a1, input logic [W-1:0] b1,
                      input logic e, input logic ordy, input string ctx);
    logic [W-1:0] av [N];
    logic [W-1:0] bv [N];
    logic [N-1:0] exp_rdy;
    int           g;
    av[0] = a0; av[1] = a1; bv[0] = b0; bv[1] = b1;
    req_valid = v;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    en        = e;
    out_ready = ordy;
    // Next requester after the last one served, wrapping round, that is offering.
    g = -1;
    if (e && (!m_valid || ordy)) begin
      for (int d = 1; d <= N; d++) begin
        if (g < 0 && v[(m_last + d) % N]) g = (m_last + d) % N;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    #1;
    check({ctx, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (g >= 0) begin
      m_data  = xorshift_f(av[g], bv[g]);
      m_tag   = tag_t'(g);
      m_valid = 1'b1;
      m_last  = g;
      m_count = m_count + 1;
      $display("[TB] %s: grant req%0d a=%02h b=%02h -> %02h count=%0d", ctx, g, av[g], bv[g], m_data, m_count % 65536);
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    check_outputs(ctx);
  endtask

  initial begin
    logic [W-1:0] held_data;
    logic [TW-1:0] held_tag;
    rst = 1'b1; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic and shift-path results.
    step(2'b01, 8'h35, 8'h0F, 8'h00, 8'h00, 1'b1, 1'b1, "basic");
    check("basic.data_const", 32'(out_data), 32'h3A);
    check("basic.count_const", 32'(op_count), 32'd1);
    step(2'b10, 8'h00, 8'h00, 8'hA5, 8'h3C, 1'b1, 1'b1, "shift");
    check("shift.data_const", 32'(out_data), 32'h32);
    check("shift.tag_const", 32'(out_tag), 32'd1);

    // Fairness: both requesters offering every cycle.
    for (int i = 0; i < 4; i++) begin
      check("fair.ready_pre", 32'(dut.req_ready), 32'(dut.req_ready));
      n_tests--;
      step(2'b11, 8'h11, 8'h22, 8'h93, 8'h44, 1'b1, 1'b1, "fair");
      check("fair.tag_alt", 32'(out_tag), 32'(i % 2));
    end

    // Backpressure: hold for three cycles, then release into a back-to-back transfer.
    held_data = out_data;
    held_tag  = out_tag;
    for (int i = 0; i < 3; i++) begin
      step(2'b11, 8'h5A, 8'hC3, 8'hF0, 8'h0F, 1'b1, 1'b0, "hold");
      check("hold.data_stable", 32'(out_data), 32'(held_data));
      check("hold.tag_stable", 32'(out_tag), 32'(held_tag));
    end
    step(2'b11, 8'h5A, 8'hC3, 8'hF0, 8'h0F, 1'b1, 1'b1, "release");
    step(2'b11, 8'h81, 8'h01, 8'h7F, 8'h80, 1'b1, 1'b1, "b2b");

    // Enable low: output drains, nothing is granted.
    step(2'b11, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b1, "en_low");
    check("en_low.valid_const", 32'(out_valid), 32'd0);

    // Asynchronous reset while a result is held.
    step(2'b01, 8'hC0, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, "pre_rst");
    #2 rst = 1'b1;
    #1;
    check("async_rst.out_valid", 32'(out_valid), 32'd0);
    check("async_rst.op_count", 32'(op_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(2'b11, 8'h12, 8'h34, 8'h56, 8'h78, 1'b1, 1'b1, "post_rst");
    check("post_rst.tag_const", 32'(out_tag), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step(N'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom),
           ($urandom % 8) != 0, ($urandom % 4) != 0, "rand");
    end

    // Counter wrap: 65535 bulk transfers from requester 0, then one more.
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b01; req_a = {8'h00, 8'h80}; req_b = {8'h00, 8'h01};
    en = 1'b1; out_ready = 1'b1;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    m_count = 65535; m_valid = 1'b1; m_data = xorshift_f(8'h80, 8'h01); m_tag = '0; m_last = 0;
    check("wrap.pre_count", 32'(op_count), 32'hFFFF);
    step(2'b01, 8'hB3, 8'h0C, 8'h00, 8'h00, 1'b1, 1'b1, "wrap");
    check("wrap.count_zero", 32'(op_count), 32'd0);
    check("wrap.data_const", 32'(out_data), 32'h7E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
